// File: rtl/stage2_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : stage2_pkg
//  Purpose  : Shared geometry and width constants for the stage-2
//             convolution window generator.
//  Revision : 1.0 - initial release
// ============================================================================
package stage2_pkg;

    localparam int ST2_Conv_IBW = 20;
    localparam int ST2_Conv_CI  = 3;
    localparam int ST2_Conv_X   = 12;
    localparam int ST2_Conv_Y   = 12;
    localparam int KX           = 5;
    localparam int KY           = 5;

    localparam int PIX_BW = ST2_Conv_CI * ST2_Conv_IBW;
    localparam int WIN_BW = KY * KX * PIX_BW;
    localparam int N_WIN  = (ST2_Conv_X - KX + 1) * (ST2_Conv_Y - KY + 1);

    localparam int COL_W = $clog2(ST2_Conv_X);
    localparam int ROW_W = $clog2(ST2_Conv_Y);

    localparam logic [COL_W-1:0] COL_LAST     = COL_W'(ST2_Conv_X - 1);
    localparam logic [ROW_W-1:0] ROW_LAST     = ROW_W'(ST2_Conv_Y - 1);
    localparam logic [COL_W-1:0] COL_EMIT_MIN = COL_W'(KX - 1);
    localparam logic [ROW_W-1:0] ROW_EMIT_MIN = ROW_W'(KY - 1);

endpackage
`default_nettype wire

// File: rtl/stage2_line_buffer.sv
`default_nettype none
// ============================================================================
//  Module   : stage2_line_buffer
//  Purpose  : One image row of pixel storage; combinational read of the old
//             entry and write of the new one share a single address.
//  Revision : 1.0 - initial release
// ============================================================================
module stage2_line_buffer
    import stage2_pkg::*;
(
    input  logic              clk,
    input  logic              i_we,
    input  logic [COL_W-1:0]  i_addr,
    input  logic [PIX_BW-1:0] i_wr_data,
    output logic [PIX_BW-1:0] o_rd_data
);

    // Storage carries no reset; its contents only matter once qualified.
    logic [PIX_BW-1:0] mem [ST2_Conv_X];

    assign o_rd_data = mem[i_addr];

    always_ff @(posedge clk) begin
        if (i_we) begin
            mem[i_addr] <= i_wr_data;
        end
    end

endmodule
`default_nettype wire

// File: rtl/stage2_conv_window_gen.sv
`default_nettype none
// ============================================================================
//  Module   : stage2_conv_window_gen
//  Purpose  : Turns the pooled raster pixel stream into 5x5xCI convolution
//             windows. Optional macro STAGE2_WIN_POS_EN adds window position.
//  Revision : 1.0 - initial release
// ============================================================================
module stage2_conv_window_gen
    import stage2_pkg::*;
(
    input  logic              clk,
    input  logic              reset,
    input  logic              i_in_valid,
    input  logic [PIX_BW-1:0] i_in_fmap,
    output logic              o_ot_valid,
    output logic [WIN_BW-1:0] o_ot_window
`ifdef STAGE2_WIN_POS_EN
    ,
    output logic [2:0]        o_ot_wrow,
    output logic [2:0]        o_ot_wcol
`endif
);

    logic [COL_W-1:0]  col_q,   col_d;
    logic [ROW_W-1:0]  row_q,   row_d;
    logic [WIN_BW-1:0] win_q,   win_d;
    logic [WIN_BW-1:0] owin_q,  owin_d;
    logic              valid_q, valid_d;
    logic              emit;

    logic [PIX_BW-1:0] lb_rd [KY-1];
    logic [PIX_BW-1:0] lb_wr [KY-1];
    logic [PIX_BW-1:0] colv  [KY];

    // A discarded beat under reset must not disturb the stored rows.
    logic lb_we;
    assign lb_we = i_in_valid & ~reset;

    generate
        for (genvar k = 0; k < KY - 1; k++) begin : g_lb
            if (k == KY - 2) begin : g_top
                assign lb_wr[k] = i_in_fmap;
            end else begin : g_mid
                assign lb_wr[k] = lb_rd[k+1];
            end
            assign colv[k] = lb_rd[k];

            stage2_line_buffer u_lb (
                .clk       (clk),
                .i_we      (lb_we),
                .i_addr    (col_q),
                .i_wr_data (lb_wr[k]),
                .o_rd_data (lb_rd[k])
            );
        end
    endgenerate

    assign colv[KY-1] = i_in_fmap;

    assign emit = i_in_valid && (row_q >= ROW_EMIT_MIN) && (col_q >= COL_EMIT_MIN);

    always_comb begin
        col_d   = col_q;
        row_d   = row_q;
        win_d   = win_q;
        owin_d  = owin_q;
        valid_d = 1'b0;
        if (i_in_valid) begin
            if (col_q == COL_LAST) begin
                col_d = '0;
                row_d = (row_q == ROW_LAST) ? '0 : row_q + 1'b1;
            end else begin
                col_d = col_q + 1'b1;
            end
            // Oldest column drops out at kx=0; the fresh column enters at KX-1.
            for (int ky = 0; ky < KY; ky++) begin
                for (int kx = 0; kx < KX; kx++) begin
                    if (kx < KX - 1) begin
                        win_d[(ky*KX+kx)*PIX_BW +: PIX_BW] = win_q[(ky*KX+kx+1)*PIX_BW +: PIX_BW];
                    end else begin
                        win_d[(ky*KX+kx)*PIX_BW +: PIX_BW] = colv[ky];
                    end
                end
            end
            if (emit) begin
                valid_d = 1'b1;
                owin_d  = win_d;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            col_q   <= '0;
            row_q   <= '0;
            win_q   <= '0;
            owin_q  <= '0;
            valid_q <= 1'b0;
        end else begin
            col_q   <= col_d;
            row_q   <= row_d;
            win_q   <= win_d;
            owin_q  <= owin_d;
            valid_q <= valid_d;
        end
    end

    assign o_ot_valid  = valid_q;
    assign o_ot_window = owin_q;

`ifdef STAGE2_WIN_POS_EN
    logic [2:0] wrow_q, wrow_d;
    logic [2:0] wcol_q, wcol_d;

    always_comb begin
        wrow_d = wrow_q;
        wcol_d = wcol_q;
        if (emit) begin
            wrow_d = 3'(row_q - ROW_EMIT_MIN);
            wcol_d = 3'(col_q - COL_EMIT_MIN);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wrow_q <= '0;
            wcol_q <= '0;
        end else begin
            wrow_q <= wrow_d;
            wcol_q <= wcol_d;
        end
    end

    assign o_ot_wrow = wrow_q;
    assign o_ot_wcol = wcol_q;
`endif

endmodule
`default_nettype wire

// File: tb/tb_stage2_conv_window_gen.sv
`default_nettype none
// ============================================================================
//  Module   : tb_stage2_conv_window_gen
//  Purpose  : Directed self-checking bench for stage2_conv_window_gen.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_stage2_conv_window_gen;
    import stage2_pkg::*;

    logic              clk;
    logic              reset;
    logic              i_in_valid;
    logic [PIX_BW-1:0] i_in_fmap;
    logic              o_ot_valid;
    logic [WIN_BW-1:0] o_ot_window;
`ifdef STAGE2_WIN_POS_EN
    logic [2:0]        o_ot_wrow;
    logic [2:0]        o_ot_wcol;
`endif

    stage2_conv_window_gen dut (
        .clk         (clk),
        .reset       (reset),
        .i_in_valid  (i_in_valid),
        .i_in_fmap   (i_in_fmap),
        .o_ot_valid  (o_ot_valid),
        .o_ot_window (o_ot_window)
`ifdef STAGE2_WIN_POS_EN
        ,
        .o_ot_wrow   (o_ot_wrow),
        .o_ot_wcol   (o_ot_wcol)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        int scen;
        int win;
        int ky;
        int kx;
        int ch;
        int expv;
    } spot_t;

    spot_t tbl [12];

    int n_tests = 0;
    int n_fail  = 0;
    int nval    = 0;
    int ncap    = 0;

    logic [WIN_BW-1:0] cap [128];
    logic              pend_valid = 1'b0;
    logic [WIN_BW-1:0] exp_win    = '0;
    int                exp_wr     = 0;
    int                exp_wc     = 0;

    function automatic logic [PIX_BW-1:0] pix(input int base, input int chsep, input int r, input int c);
        logic [PIX_BW-1:0] p;
        for (int ch = 0; ch < ST2_Conv_CI; ch++)
            p[ch*ST2_Conv_IBW +: ST2_Conv_IBW] = ST2_Conv_IBW'(base + r*ST2_Conv_X + c + ch*chsep);
        return p;
    endfunction

    function automatic logic [WIN_BW-1:0] model_win(input int base, input int chsep, input int wr, input int wc);
        logic [WIN_BW-1:0] w;
        for (int ky = 0; ky < KY; ky++)
            for (int kx = 0; kx < KX; kx++)
                w[(ky*KX+kx)*PIX_BW +: PIX_BW] = pix(base, chsep, wr + ky, wc + kx);
        return w;
    endfunction

    function automatic int elem(input logic [WIN_BW-1:0] w, input int ky, input int kx, input int ch);
        return int'(w[((ky*KX+kx)*ST2_Conv_CI+ch)*ST2_Conv_IBW +: ST2_Conv_IBW]);
    endfunction

    function automatic int first_diff(input logic [WIN_BW-1:0] a, input logic [WIN_BW-1:0] b);
        for (int i = 0; i < KY*KX*ST2_Conv_CI; i++)
            if (a[i*ST2_Conv_IBW +: ST2_Conv_IBW] !== b[i*ST2_Conv_IBW +: ST2_Conv_IBW]) return i;
        return -1;
    endfunction

    // One clock: check what the previous beat should have produced, then drive the next.
    task automatic cycle(input logic rst_in, input logic v, input int base, input int chsep,
                         input int r, input int c);
        int d;
        @(negedge clk);
        n_tests++;
        if (o_ot_valid !== pend_valid) begin
            n_fail++;
            $display("FAIL valid: got %b expected %b at %0t", o_ot_valid, pend_valid, $time);
        end
        n_tests++;
        if (o_ot_window !== exp_win) begin
            n_fail++;
            d = first_diff(o_ot_window, exp_win);
            $display("FAIL window: element %0d got %0d expected %0d at %0t", d,
                     o_ot_window[d*ST2_Conv_IBW +: ST2_Conv_IBW], exp_win[d*ST2_Conv_IBW +: ST2_Conv_IBW], $time);
        end
`ifdef STAGE2_WIN_POS_EN
        n_tests++;
        if (o_ot_wrow !== 3'(exp_wr) || o_ot_wcol !== 3'(exp_wc)) begin
            n_fail++;
            $display("FAIL wpos: got %0d/%0d expected %0d/%0d at %0t", o_ot_wrow, o_ot_wcol, exp_wr, exp_wc, $time);
        end
`endif
        if (o_ot_valid === 1'b1) begin
            nval++;
            if (ncap < 128) begin
                cap[ncap] = o_ot_window;
                ncap++;
            end
        end
        reset      = rst_in;
        i_in_valid = v;
        i_in_fmap  = v ? pix(base, chsep, r, c) : '0;
        if (rst_in) begin
            pend_valid = 1'b0;
            exp_win    = '0;
            exp_wr     = 0;
            exp_wc     = 0;
        end else if (v && r >= KY - 1 && c >= KX - 1) begin
            pend_valid = 1'b1;
            exp_win    = model_win(base, chsep, r - (KY - 1), c - (KX - 1));
            exp_wr     = r - (KY - 1);
            exp_wc     = c - (KX - 1);
        end else begin
            pend_valid = 1'b0;
        end
    endtask

    task automatic idle();
        cycle(1'b0, 1'b0, 0, 0, 0, 0);
    endtask

    task automatic frame(input int base, input int chsep, input int gap);
        for (int r = 0; r < ST2_Conv_Y; r++)
            for (int c = 0; c < ST2_Conv_X; c++) begin
                repeat (gap) idle();
                cycle(1'b0, 1'b1, base, chsep, r, c);
            end
    endtask

    task automatic check_count(input string name, input int expv);
        n_tests++;
        if (nval != expv) begin
            n_fail++;
            $display("FAIL %s: got %0d windows expected %0d", name, nval, expv);
        end
    endtask

    task automatic apply_table(input int scen);
        int got;
        for (int i = 0; i < 12; i++) begin
            if (tbl[i].scen == scen) begin
                n_tests++;
                got = (tbl[i].win < ncap) ? elem(cap[tbl[i].win], tbl[i].ky, tbl[i].kx, tbl[i].ch) : -1;
                if (got != tbl[i].expv) begin
                    n_fail++;
                    $display("FAIL spot[%0d] win%0d (%0d,%0d) ch%0d: got %0d expected %0d",
                             i, tbl[i].win, tbl[i].ky, tbl[i].kx, tbl[i].ch, got, tbl[i].expv);
                end
            end
        end
    endtask

    initial begin
        tbl[0]  = '{0, 0,  0, 0, 0, 0};
        tbl[1]  = '{0, 0,  0, 4, 0, 4};
        tbl[2]  = '{0, 0,  4, 0, 0, 48};
        tbl[3]  = '{0, 0,  4, 4, 0, 52};
        tbl[4]  = '{0, 63, 0, 0, 0, 91};
        tbl[5]  = '{0, 63, 4, 4, 0, 143};
        tbl[6]  = '{1, 0,  2, 3, 0, 27};
        tbl[7]  = '{1, 0,  2, 3, 1, 1027};
        tbl[8]  = '{1, 0,  2, 3, 2, 2027};
        tbl[9]  = '{2, 64, 0, 0, 0, 500};
        tbl[10] = '{2, 64, 4, 4, 0, 552};
        tbl[11] = '{3, 29, 0, 0, 0, 41};

        reset      = 1'b1;
        i_in_valid = 1'b0;
        i_in_fmap  = '0;
        repeat (2) @(posedge clk);
        cycle(1'b1, 1'b0, 0, 0, 0, 0);
        cycle(1'b0, 1'b0, 0, 0, 0, 0);

        // Gapless ramp frame
        ncap = 0; nval = 0;
        frame(0, 0, 0);
        idle();
        check_count("ramp_count", N_WIN);
        apply_table(0);
        apply_table(3);

        // Channel separation
        ncap = 0; nval = 0;
        frame(0, 1000, 0);
        idle();
        apply_table(1);

        // Valid every third cycle
        ncap = 0; nval = 0;
        frame(0, 0, 2);
        idle();
        check_count("gapped_count", N_WIN);
        apply_table(0);

        // Back-to-back frames
        ncap = 0; nval = 0;
        frame(0, 0, 0);
        frame(500, 0, 0);
        idle();
        check_count("b2b_count", 2 * N_WIN);
        apply_table(2);

        // Reset mid-frame with a beat presented during reset
        for (int i = 0; i < 30; i++)
            cycle(1'b0, 1'b1, 0, 0, i / ST2_Conv_X, i % ST2_Conv_X);
        cycle(1'b1, 1'b1, 0, 0, 2, 6);
        idle();
        ncap = 0; nval = 0;
        frame(0, 0, 0);
        idle();
        check_count("post_reset_count", N_WIN);
        apply_table(0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
